reg_file_2r1w: RTL
==================

// Module: reg_file_2r1w
// PURPOSE
//  Parametrised register bank, successor to the fixed 16x32 register file.
//  One write port with byte strobes and two independent synchronous read ports
//  with same-cycle write bypass. A clear sequencer zeroes the whole bank on request.
//  Sits between the control datapath and the local bus as shared scratch/config storage.
// PARAMETERS
//  DATA_W  32  word width in bits; must be a multiple of 8 (NB = DATA_W/8 byte lanes)
//  DEPTH   16  number of words; 2 <= DEPTH <= 2**ADDR_W
//  ADDR_W  4   address width for wr_addr, rd_addr_a, rd_addr_b
// PORTS
//  clk         in   1       single clock, rising edge
//  reset_n     in   1       asynchronous active-low reset
//  write_en    in   1       write request, sampled on clk rise
//  wr_addr     in   ADDR_W  write address
//  data_in     in   DATA_W  write data
//  byte_en     in   NB      byte lane strobes; bit i covers data_in[8i+7:8i]
//  rd_en_a     in   1       read request, port A
//  rd_addr_a   in   ADDR_W  read address, port A
//  data_out_a  out  DATA_W  read data, port A (registered)
//  rd_valid_a  out  1       data_out_a updated this cycle
//  rd_en_b     in   1       read request, port B
//  rd_addr_b   in   ADDR_W  read address, port B
//  data_out_b  out  DATA_W  read data, port B (registered)
//  rd_valid_b  out  1       data_out_b updated this cycle
//  clear_req   in   1       start bank clear (level, sampled in IDLE only)
//  busy        out  1       clear sequence in progress
//  wr_err      out  1       one-cycle pulse: previous write was rejected
// BEHAVIOUR
//  Reset (reset_n low, async): all DEPTH words = 0; data_out_a/b = 0; rd_valid_a/b = 0;
//   busy = 0; wr_err = 0; FSM = IDLE; clr_ptr = 0. Leaving reset does not need a clock.
//  Write: accepted when write_en & !busy & wr_addr < DEPTH. Only lanes with byte_en[i]=1
//   are updated; other lanes keep old value. byte_en = 0 is a legal no-op (no error).
//  Rejected write (write_en & (busy | wr_addr >= DEPTH)): storage untouched;
//   wr_err = 1 for exactly the next cycle. Back-to-back rejects hold wr_err high.
//  Read (each port independent, same rules): rd_en high at edge N -> data_out and
//   rd_valid = 1 after edge N (latency 1). rd_en low -> rd_valid = 0, data_out holds.
//   rd_addr >= DEPTH -> data_out = 0, rd_valid = 1. Both ports may read the same address.
//  Bypass: accepted write at edge N and read of the same address at edge N ->
//   data_out = merged word (new bytes in enabled lanes, old bytes elsewhere).
//  Clear FSM, states IDLE / CLEAR:
//   IDLE: clear_req = 1 at edge N -> CLEAR, clr_ptr = 0, busy = 1 after edge N.
//   CLEAR: each edge writes mem[clr_ptr] = 0 and increments clr_ptr; on clr_ptr = DEPTH-1
//    clears that word, returns to IDLE, busy = 0 after that edge. busy is high for
//    exactly DEPTH cycles. clear_req during CLEAR is ignored (no restart, no queueing).
//   Write accepted in the same IDLE cycle that clear_req is sampled: performed, then erased.
//   Reads during CLEAR: data_out = 0, rd_valid follows rd_en as normal.
//  Reset mid-clear: bank zeroed immediately, FSM = IDLE, busy = 0.
//  Arithmetic: clr_ptr is ADDR_W bits; wrap detection uses compare to DEPTH-1, never overflow,
//   so non-power-of-2 DEPTH is supported.
// TESTING
//  1. Reset: drive reset_n low mid-cycle -> all outputs 0 without a clk edge; read all 16 -> 0.
//  2. Byte strobes: write 0xAABBCCDD @3 be=1111, then 0x11223344 @3 be=0101 ->
//     read A @3 returns 0xAA22CC44 one cycle after rd_en_a, rd_valid_a = 1 for one cycle.
//  3. Bypass: write 0xDEADBEEF @5 be=1111 while rd_en_a@5 and rd_en_b@5 same edge ->
//     both ports return 0xDEADBEEF next cycle.
//  4. Errors: DEPTH=12, write @13 -> wr_err pulses 1 cycle, read @13 returns 0 valid=1;
//     write @2 with be=0000 -> no wr_err, word unchanged.
//  5. Clear: fill all words with index value, pulse clear_req -> busy high exactly DEPTH
//     cycles; write during busy -> wr_err, ignored; afterwards every word reads 0.
//  6. Reset at clr_ptr=7 of a clear -> busy 0 immediately; a new clear_req starts at ptr 0.

Source files
------------

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one byte-strobed write port, two read ports,
// bank-clear request and status.
interface reg_file_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    localparam int NB = DATA_W / 8;

    logic              write_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] data_in;
    logic [NB-1:0]     byte_en;

    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] data_out_a;
    logic              rd_valid_a;

    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] data_out_b;
    logic              rd_valid_b;

    logic              clear_req;
    logic              busy;
    logic              wr_err;

    modport master (
        output write_en, wr_addr, data_in, byte_en,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clear_req,
        input  data_out_a, rd_valid_a, data_out_b, rd_valid_b, busy, wr_err
    );

    modport slave (
        input  write_en, wr_addr, data_in, byte_en,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clear_req,
        output data_out_a, rd_valid_a, data_out_b, rd_valid_b, busy, wr_err
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Parametrised 2-read/1-write register bank with byte strobes, same-cycle
// write-to-read bypass and a sequential clear engine.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic             clk,
    input logic             reset_n,
    reg_file_2r1w_if.slave  bus
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range, wr_ok, wr_rej;
    logic [DATA_W-1:0] wr_word;
    logic              a_in_range, b_in_range;
    logic [DATA_W-1:0] rd_word_a, rd_word_b;

    logic [DATA_W-1:0] data_out_a, data_out_b;
    logic              rd_valid_a, rd_valid_b, wr_err;

    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_V);
    assign wr_ok       = bus.write_en && (state == IDLE) && wr_in_range;
    assign wr_rej      = bus.write_en && !wr_ok;
    assign a_in_range  = ({1'b0, bus.rd_addr_a} < DEPTH_V);
    assign b_in_range  = ({1'b0, bus.rd_addr_b} < DEPTH_V);

    // Merged word: new bytes in strobed lanes, stored bytes elsewhere.
    always_comb begin
        wr_word = wr_in_range ? mem[bus.wr_addr] : '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (bus.byte_en[b]) wr_word[8*b +: 8] = bus.data_in[8*b +: 8];
        end
    end

    always_comb begin
        rd_word_a = '0;
        if (state == IDLE && a_in_range) begin
            if (wr_ok && bus.wr_addr == bus.rd_addr_a) rd_word_a = wr_word;
            else                                        rd_word_a = mem[bus.rd_addr_a];
        end
    end

    always_comb begin
        rd_word_b = '0;
        if (state == IDLE && b_in_range) begin
            if (wr_ok && bus.wr_addr == bus.rd_addr_b) rd_word_b = wr_word;
            else                                        rd_word_b = mem[bus.rd_addr_b];
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            CLEAR: begin
                if (clr_ptr == LAST) begin
                    state_next   = IDLE;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_ptr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // A write accepted on the edge that starts a clear still lands; the clear erases it later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (state == CLEAR && clr_ptr == ADDR_W'(i))
                    mem[i] <= '0;
                else if (wr_ok && bus.wr_addr == ADDR_W'(i))
                    mem[i] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_a <= '0;
            data_out_b <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            if (bus.rd_en_a) data_out_a <= rd_word_a;
            if (bus.rd_en_b) data_out_b <= rd_word_b;
            rd_valid_a <= bus.rd_en_a;
            rd_valid_b <= bus.rd_en_b;
            wr_err     <= wr_rej;
        end
    end

    assign bus.data_out_a = data_out_a;
    assign bus.data_out_b = data_out_b;
    assign bus.rd_valid_a = rd_valid_a;
    assign bus.rd_valid_b = rd_valid_b;
    assign bus.wr_err     = wr_err;
    assign bus.busy       = (state == CLEAR);
endmodule
